lm_sm_sequencer: RTL and testbench
==================================

# lm_sm_sequencer

Multi-cycle sequencer for the LM (load multiple) and SM (store multiple) instructions of the pipelined processor. It sits in the execute/memory stage. It walks an 8-bit register mask from R0 to R7 and issues one register-file access and one data-memory access per set bit, using consecutive memory addresses from a base. It drives the register bank's read-address and write-address/enable ports and stalls the front of the pipeline while a transfer is in progress.

## Interface
Parameters:
- AW, 16, memory address and data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin an LM/SM; sampled only in IDLE
- is_lm  in  1  1 = LM (memory -> registers), 0 = SM (registers -> memory); captured with start
- reg_mask  in  8  bit i set = transfer Ri; captured with start
- base_addr  in  AW  first memory address; captured with start
- base_reg  in  3  register holding the base; captured with start, used only by LMSM_BASE_WB_EN
- stall  in  1  downstream stall; freezes the sequencer
- busy  out  1  high from the cycle after an accepted start until DONE exits; used as the fetch/decode stall
- rf_rd_addr  out  3  register bank read address (SM data source)
- rf_wr_addr  out  3  register bank write address
- rf_wr_en  out  1  register bank write enable
- rf_wr_sel  out  1  0 = write memory read data; 1 = write wb_data
- wb_data  out  AW  base writeback value
- mem_addr  out  AW  data memory address
- mem_rd_en  out  1  memory read strobe (LM)
- mem_wr_en  out  1  memory write strobe (SM)
- done  out  1  one-cycle pulse when the sequence completes

## Operation
- States: IDLE, RUN, WB (only with the macro), DONE.
- IDLE:
  - All outputs are 0.
  - If start=1 at a clock edge, capture is_lm, reg_mask, base_addr and base_reg, and clear the counter k.
  - Non-zero mask -> RUN. Zero mask -> DONE (no accesses are issued).
- RUN, per cycle with stall=0:
  - Select the current register c, the lowest set bit of the remaining mask.
  - Set mem_addr = base_addr + k (mod 2^AW).
  - LM: mem_rd_en=1, rf_wr_addr=c, rf_wr_sel=0, rf_wr_en=1. Exception: c=7 gives rf_wr_en=0, because R7/PC is not writable through this port.
  - SM: rf_rd_addr=c, mem_wr_en=1, rf_wr_en=0.
  - At the clock edge, clear bit c and increment k.
  - When the remaining mask becomes 0: go to WB if the macro is defined, otherwise DONE.
- stall=1 in any state: state, mask, k and all outputs hold their values. Strobes stay asserted, but no progress is made, so downstream logic must gate on stall.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- start while busy=1 is ignored.
- reset in any state: IDLE next cycle. The mask and k are cleared and all outputs go to 0. No partial-completion done pulse is generated.
- Address arithmetic is AW bits wide and wraps: 16'hFFFF + 1 = 16'h0000.

## Timing
- Outputs are registered. The first access is presented in the cycle after start is sampled.
- Latency with no stalls, for a mask with n set bits:
  - n RUN cycles, plus 1 WB cycle if enabled, plus 1 DONE cycle.
  - done asserts n+1 cycles after the start edge (n+2 with writeback).
- Mask of zero: done asserts 1 cycle after start.
- busy rises in the cycle after start and falls in the cycle after done.
- Each stall cycle adds exactly one cycle to the sequence.
- Reset value of every output is 0.

## Configuration
- LMSM_BASE_WB_EN defined:
  - After the last transfer, a WB cycle drives rf_wr_en=1, rf_wr_addr=base_reg, rf_wr_sel=1 and wb_data = base_addr + n.
  - If base_reg=7, rf_wr_en stays 0.
  - A zero mask skips WB.
- Not defined:
  - No WB state exists.
  - rf_wr_sel and wb_data are tied to 0.

## Test plan
- LM, mask=8'b0000_0101, base=16'h0010 -> cycle 1: rf_wr_addr=0, mem_addr=16'h0010; cycle 2: rf_wr_addr=2, mem_addr=16'h0011; done at cycle 3 (or 4 with the macro, WB writing 16'h0012).
- SM, mask=8'hFF, base=16'hFFFE -> rf_rd_addr runs 0..7; mem_addr runs FFFE, FFFF, 0000 ... 0005; mem_wr_en is high for 8 cycles.
- LM, mask=8'h80 -> one cycle with mem_rd_en=1 and rf_wr_en=0; then done.
- mask=8'h00 -> no strobes; done 1 cycle after start; busy=1 only during DONE.
- SM, mask=8'h06 with stall held for 2 cycles on the first access -> rf_rd_addr=1 held 3 cycles; then 2; done delayed by 2.
- reset asserted during the RUN cycle for R3 of mask 8'h0F -> next cycle all outputs are 0 with no done pulse; a new start is then accepted normally.

Source files
------------

// File: rtl/lm_sm_sequencer.sv
// LM/SM multi-cycle sequencer: walks an 8-bit register mask R0..R7,
// issuing one RF access and one memory access per set bit.
// Optional base-register writeback when LMSM_BASE_WB_EN is defined.
// Ports: clk, reset (sync, active-high), start, is_lm, reg_mask,
//   base_addr, base_reg, stall -> busy, rf_rd_addr, rf_wr_addr,
//   rf_wr_en, rf_wr_sel, wb_data, mem_addr, mem_rd_en, mem_wr_en, done.
// All outputs are registered; stall freezes state and outputs.
module lm_sm_sequencer #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          is_lm,
  input  logic [7:0]    reg_mask,
  input  logic [AW-1:0] base_addr,
  input  logic [2:0]    base_reg,
  input  logic          stall,
  output logic          busy,
  output logic [2:0]    rf_rd_addr,
  output logic [2:0]    rf_wr_addr,
  output logic          rf_wr_en,
  output logic          rf_wr_sel,
  output logic [AW-1:0] wb_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic          done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
`ifdef LMSM_BASE_WB_EN
  localparam logic [1:0] S_WB   = 2'd2;
`endif
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [2:0] f_low(input logic [7:0] m);
    f_low = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) f_low = 3'(i);
  endfunction

  logic [1:0]    r_state, n_state;
  logic [7:0]    r_mask, n_mask;
  logic [3:0]    r_k, n_k;
  logic          r_lm, n_lm;
  logic [AW-1:0] r_base, n_base;

  logic          r_busy, n_busy;
  logic [2:0]    r_rd_addr, n_rd_addr;
  logic [2:0]    r_wr_addr, n_wr_addr;
  logic          r_wr_en, n_wr_en;
  logic [AW-1:0] r_mem_addr, n_mem_addr;
  logic          r_rd_en, n_rd_en;
  logic          r_mwr_en, n_mwr_en;
  logic          r_done, n_done;

`ifdef LMSM_BASE_WB_EN
  logic [2:0]    r_breg, n_breg;
  logic          r_wr_sel, n_wr_sel;
  logic [AW-1:0] r_wb_data, n_wb_data;
`endif

  // r_mask holds the bits still to transfer, including the one
  // currently presented; w_rem is that mask with the current bit gone.
  logic [7:0]    w_rem;
  logic          w_acc;
  logic [2:0]    w_c;
  logic [AW-1:0] w_addr;
  logic          w_lm;

  assign w_rem = r_mask & (r_mask - 8'd1);

  always_comb begin
    n_state    = r_state;
    n_mask     = r_mask;
    n_k        = r_k;
    n_lm       = r_lm;
    n_base     = r_base;
    n_busy     = 1'b0;
    n_rd_addr  = 3'd0;
    n_wr_addr  = 3'd0;
    n_wr_en    = 1'b0;
    n_mem_addr = '0;
    n_rd_en    = 1'b0;
    n_mwr_en   = 1'b0;
    n_done     = 1'b0;
`ifdef LMSM_BASE_WB_EN
    n_breg     = r_breg;
    n_wr_sel   = 1'b0;
    n_wb_data  = '0;
`endif
    w_acc      = 1'b0;
    w_c        = 3'd0;
    w_addr     = '0;
    w_lm       = r_lm;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          n_lm   = is_lm;
          n_mask = reg_mask;
          n_k    = 4'd0;
          n_base = base_addr;
`ifdef LMSM_BASE_WB_EN
          n_breg = base_reg;
`endif
          if (reg_mask != 8'd0) begin
            n_state = S_RUN;
            w_acc   = 1'b1;
            w_c     = f_low(reg_mask);
            w_addr  = base_addr;
            w_lm    = is_lm;
          end else begin
            n_state = S_DONE;
            n_busy  = 1'b1;
            n_done  = 1'b1;
          end
        end
      end
      S_RUN: begin
        n_mask = w_rem;
        n_k    = r_k + 4'd1;
        if (w_rem != 8'd0) begin
          w_acc  = 1'b1;
          w_c    = f_low(w_rem);
          w_addr = r_base + AW'(n_k);
        end else begin
`ifdef LMSM_BASE_WB_EN
          n_state   = S_WB;
          n_busy    = 1'b1;
          n_wr_addr = r_breg;
          n_wr_sel  = 1'b1;
          // R7 is the PC and cannot be written through this port
          n_wr_en   = (r_breg != 3'd7);
          n_wb_data = r_base + AW'(n_k);
`else
          n_state = S_DONE;
          n_busy  = 1'b1;
          n_done  = 1'b1;
`endif
        end
      end
`ifdef LMSM_BASE_WB_EN
      S_WB: begin
        n_state = S_DONE;
        n_busy  = 1'b1;
        n_done  = 1'b1;
      end
`endif
      S_DONE: begin
        n_state = S_IDLE;
        n_mask  = 8'd0;
        n_k     = 4'd0;
      end
      default: begin
        n_state = S_IDLE;
      end
    endcase

    if (w_acc) begin
      n_busy     = 1'b1;
      n_mem_addr = w_addr;
      if (w_lm) begin
        n_rd_en   = 1'b1;
        n_wr_addr = w_c;
        n_wr_en   = (w_c != 3'd7);
      end else begin
        n_mwr_en  = 1'b1;
        n_rd_addr = w_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mask     <= 8'd0;
      r_k        <= 4'd0;
      r_lm       <= 1'b0;
      r_base     <= '0;
      r_busy     <= 1'b0;
      r_rd_addr  <= 3'd0;
      r_wr_addr  <= 3'd0;
      r_wr_en    <= 1'b0;
      r_mem_addr <= '0;
      r_rd_en    <= 1'b0;
      r_mwr_en   <= 1'b0;
      r_done     <= 1'b0;
    end else if (!stall) begin
      r_state    <= n_state;
      r_mask     <= n_mask;
      r_k        <= n_k;
      r_lm       <= n_lm;
      r_base     <= n_base;
      r_busy     <= n_busy;
      r_rd_addr  <= n_rd_addr;
      r_wr_addr  <= n_wr_addr;
      r_wr_en    <= n_wr_en;
      r_mem_addr <= n_mem_addr;
      r_rd_en    <= n_rd_en;
      r_mwr_en   <= n_mwr_en;
      r_done     <= n_done;
    end
  end

`ifdef LMSM_BASE_WB_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_breg    <= 3'd0;
      r_wr_sel  <= 1'b0;
      r_wb_data <= '0;
    end else if (!stall) begin
      r_breg    <= n_breg;
      r_wr_sel  <= n_wr_sel;
      r_wb_data <= n_wb_data;
    end
  end

  assign rf_wr_sel = r_wr_sel;
  assign wb_data   = r_wb_data;
`else
  // base_reg only matters for writeback
  logic w_unused_breg;
  assign w_unused_breg = ^base_reg;

  assign rf_wr_sel = 1'b0;
  assign wb_data   = '0;
`endif

  assign busy       = r_busy;
  assign rf_rd_addr = r_rd_addr;
  assign rf_wr_addr = r_wr_addr;
  assign rf_wr_en   = r_wr_en;
  assign mem_addr   = r_mem_addr;
  assign mem_rd_en  = r_rd_en;
  assign mem_wr_en  = r_mwr_en;
  assign done       = r_done;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: directed cases plus
// randomized traffic compared every cycle against a transaction model.
module tb_lm_sm_sequencer;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset, start, is_lm, stall;
  logic [7:0]    reg_mask;
  logic [AW-1:0] base_addr;
  logic [2:0]    base_reg;
  logic          busy, rf_wr_en, rf_wr_sel;
  logic [2:0]    rf_rd_addr, rf_wr_addr;
  logic [AW-1:0] wb_data, mem_addr;
  logic          mem_rd_en, mem_wr_en, done;

  lm_sm_sequencer #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .is_lm(is_lm),
    .reg_mask(reg_mask), .base_addr(base_addr), .base_reg(base_reg),
    .stall(stall), .busy(busy), .rf_rd_addr(rf_rd_addr),
    .rf_wr_addr(rf_wr_addr), .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel),
    .wb_data(wb_data), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          busy;
    logic [2:0]    rd_addr;
    logic [2:0]    wr_addr;
    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wb_data;
    logic [AW-1:0] mem_addr;
    logic          rd_en;
    logic          mwr_en;
    logic          done;
  } ov_t;

  ov_t dut_o;
  assign dut_o = {busy, rf_rd_addr, rf_wr_addr, rf_wr_en, rf_wr_sel,
                  wb_data, mem_addr, mem_rd_en, mem_wr_en, done};

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: a transaction is the list of output vectors it must show,
  // one per unstalled cycle; cur is what the outputs must be now.
  ov_t cur = '0;
  ov_t q[$];

  function automatic void build(input logic lm, input logic [7:0] m,
                                input logic [AW-1:0] b,
                                input logic [2:0] br);
    ov_t e;
    int  n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        e = '0;
        e.busy = 1'b1;
        e.mem_addr = b + AW'(n);
        if (lm) begin
          e.rd_en = 1'b1;
          e.wr_addr = 3'(i);
          e.wr_en = (i != 7);
        end else begin
          e.mwr_en = 1'b1;
          e.rd_addr = 3'(i);
        end
        q.push_back(e);
        n++;
      end
    end
`ifdef LMSM_BASE_WB_EN
    if (n > 0) begin
      e = '0;
      e.busy = 1'b1;
      e.wr_addr = br;
      e.wr_sel = 1'b1;
      e.wr_en = (br != 3'd7);
      e.wb_data = b + AW'(n);
      q.push_back(e);
    end
`else
    if (br == 3'd0) e = '0;
`endif
    e = '0;
    e.busy = 1'b1;
    e.done = 1'b1;
    q.push_back(e);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      cur = '0;
      q.delete();
    end else if (stall) begin
      cur = cur;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (start && !cur.busy) begin
      build(is_lm, reg_mask, base_addr, base_reg);
      cur = q.pop_front();
    end else begin
      cur = '0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (dut_o !== cur) begin
        errors++;
        $display("FAIL model t=%0t got %h want %h", $time, dut_o, cur);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic lm, input logic [7:0] m,
                             input logic [AW-1:0] b,
                             input logic [2:0] br);
    is_lm = lm;
    reg_mask = m;
    base_addr = b;
    base_reg = br;
    stall = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] ea;
    reset = 1'b1;
    start = 1'b0;
    is_lm = 1'b0;
    stall = 1'b0;
    reg_mask = 8'd0;
    base_addr = '0;
    base_reg = 3'd0;
    step();
    chk_en = 1'b1;
    step();
    lit("rst busy", 32'(busy), 32'd0);
    lit("rst done", 32'(done), 32'd0);
    lit("rst mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    step();

    // LM 0x05 from 0x0010
    drive_start(1'b1, 8'h05, 16'h0010, 3'd3);
    lit("lm05 c1 wr_addr", 32'(rf_wr_addr), 32'd0);
    lit("lm05 c1 addr", 32'(mem_addr), 32'h0010);
    lit("lm05 c1 rd_en", 32'(mem_rd_en), 32'd1);
    step();
    lit("lm05 c2 wr_addr", 32'(rf_wr_addr), 32'd2);
    lit("lm05 c2 addr", 32'(mem_addr), 32'h0011);
    step();
`ifdef LMSM_BASE_WB_EN
    lit("lm05 wb data", 32'(wb_data), 32'h0012);
    lit("lm05 wb addr", 32'(rf_wr_addr), 32'd3);
    step();
`endif
    lit("lm05 done", 32'(done), 32'd1);
    step();
    lit("lm05 busy off", 32'(busy), 32'd0);
    step();

    // SM 0xFF from 0xFFFE, wraps
    drive_start(1'b0, 8'hFF, 16'hFFFE, 3'd1);
    for (int i = 0; i < 8; i++) begin
      ea = 16'hFFFE + 16'(i);
      lit("smff rd_addr", 32'(rf_rd_addr), 32'(i));
      lit("smff addr", 32'(mem_addr), 32'(ea));
      lit("smff wr_en", 32'(mem_wr_en), 32'd1);
      step();
    end
    lit("smff strobe off", 32'(mem_wr_en), 32'd0);
    repeat (3) step();

    // LM of R7 only
    drive_start(1'b1, 8'h80, 16'h0300, 3'd7);
    lit("lm80 rd_en", 32'(mem_rd_en), 32'd1);
    lit("lm80 wr_en", 32'(rf_wr_en), 32'd0);
    repeat (3) step();

    // zero mask
    drive_start(1'b1, 8'h00, 16'h0400, 3'd2);
    lit("zero done", 32'(done), 32'd1);
    lit("zero busy", 32'(busy), 32'd1);
    lit("zero rd_en", 32'(mem_rd_en), 32'd0);
    step();
    lit("zero busy off", 32'(busy), 32'd0);
    step();

    // SM 0x06 with two stall cycles on the first access
    drive_start(1'b0, 8'h06, 16'h0500, 3'd4);
    stall = 1'b1;
    lit("stall c1", 32'(rf_rd_addr), 32'd1);
    step();
    lit("stall c2", 32'(rf_rd_addr), 32'd1);
    step();
    stall = 1'b0;
    lit("stall c3", 32'(rf_rd_addr), 32'd1);
    step();
    lit("stall c4", 32'(rf_rd_addr), 32'd2);
    step();
`ifdef LMSM_BASE_WB_EN
    step();
`endif
    lit("stall done", 32'(done), 32'd1);
    repeat (2) step();

    // reset in the middle of LM 0x0F
    drive_start(1'b1, 8'h0F, 16'h0100, 3'd0);
    repeat (3) step();
    lit("rst mid R3", 32'(rf_wr_addr), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    lit("rst mid busy", 32'(busy), 32'd0);
    lit("rst mid done", 32'(done), 32'd0);
    lit("rst mid rd_en", 32'(mem_rd_en), 32'd0);
    drive_start(1'b0, 8'h01, 16'h0200, 3'd0);
    lit("after rst wr_en", 32'(mem_wr_en), 32'd1);
    lit("after rst addr", 32'(mem_addr), 32'h0200);
    repeat (4) step();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(3) == 0);
      is_lm = 1'($urandom_range(1));
      case ($urandom_range(7))
        0: reg_mask = 8'h00;
        1: reg_mask = 8'hFF;
        default: reg_mask = 8'($urandom);
      endcase
      base_addr = ($urandom_range(3) == 0) ?
                  16'hFFFF - 16'($urandom_range(6)) : 16'($urandom);
      base_reg = 3'($urandom_range(7));
      stall = ($urandom_range(4) == 0);
      reset = ($urandom_range(199) == 0);
      step();
    end
    start = 1'b0;
    stall = 1'b0;
    reset = 1'b0;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
